// File: rtl/montgomery_digit_sequencer_pkg.sv
// Shared definitions for the radix-4 Montgomery digit sequencer: multiplexer
// select codes, FSM state type and the per-modulus constant helpers.
package montgomery_pkg;

    localparam logic [2:0] SEL_ZERO = 3'b000;
    localparam logic [2:0] SEL_M    = 3'b001;
    localparam logic [2:0] SEL_2M   = 3'b010;
    localparam logic [2:0] SEL_3M   = 3'b011;
    localparam logic [2:0] SEL_B    = 3'b100;
    localparam logic [2:0] SEL_2B   = 3'b101;
    localparam logic [2:0] SEL_3B   = 3'b110;

    typedef enum logic [2:0] {
        StIdle,
        StAddB,
        StWaitB,
        StAddM,
        StWaitM,
        StFinish
    } state_e;

    // -M^-1 mod 4 depends only on M[1:0]; M odd gives 01 -> 3, 11 -> 1.
    function automatic logic [1:0] m_prime4(input logic [1:0] m_low);
        return (m_low == 2'b01) ? 2'd3 : 2'd1;
    endfunction

    function automatic logic [2:0] b_select(input logic [1:0] digit);
        logic [1:0] dm1;
        dm1 = digit - 2'd1;
        return (digit != 2'b00) ? {1'b1, dm1} : SEL_ZERO;
    endfunction

endpackage

// File: rtl/montgomery_digit_sequencer_if.sv
// Handshake bundle between the digit sequencer (slave) and its controller /
// adder datapath (master).
interface montgomery_digit_sequencer_if #(
    parameter int unsigned N_BITS = 1024
) ();

    logic              start;
    logic [N_BITS-1:0] in_A;
    logic [1:0]        m_low;
    logic [1:0]        c_low;
    logic              add_done;
    logic [2:0]        select;
    logic              sel_valid;
    logic              busy;
    logic              last_iter;
    logic              done;

    modport master (
        output start, in_A, m_low, c_low, add_done,
        input  select, sel_valid, busy, last_iter, done
    );

    modport slave (
        input  start, in_A, m_low, c_low, add_done,
        output select, sel_valid, busy, last_iter, done
    );

endinterface

// File: rtl/montgomery_digit_sequencer.sv
// Walks operand A in radix-4 digits, issuing one B-multiple and one M-multiple
// select per digit and waiting for the adder between them.
module montgomery_digit_sequencer
    import montgomery_pkg::*;
#(
    parameter  int unsigned N_BITS   = 1024,
    localparam int unsigned N_DIGITS = N_BITS / 2,
    localparam int unsigned CNT_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input logic                         clk,
    input logic                         resetn,
    montgomery_digit_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_DIGITS - 1);

    state_e            state_q, state_d;
    logic [N_BITS-1:0] a_sr_q, a_sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        q_q, q_d;
    logic [1:0]        mp_q, mp_d;
    logic [3:0]        q_prod;

    logic [2:0] select_q, select_d;
    logic       sel_valid_q, sel_valid_d;
    logic       busy_q, busy_d;
    logic       last_iter_q, last_iter_d;
    logic       done_q, done_d;

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        mp_d    = mp_q;
        q_prod  = {2'b00, bus.c_low} * {2'b00, mp_q};

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_sr_d  = bus.in_A;
                    cnt_d   = '0;
                    mp_d    = m_prime4(bus.m_low);
                    state_d = StAddB;
                end
            end
            StAddB:  state_d = StWaitB;
            StWaitB: begin
                if (bus.add_done) begin
                    q_d     = q_prod[1:0];
                    state_d = StAddM;
                end
            end
            StAddM:  state_d = StWaitM;
            StWaitM: begin
                if (bus.add_done) begin
                    a_sr_d = a_sr_q >> 2;
                    if (cnt_q == LAST_CNT) begin
                        state_d = StFinish;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = StAddB;
                    end
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        // Outputs are registered, so they are derived from the next state.
        select_d = select_q;
        if (state_d == StAddB) begin
            select_d = b_select(a_sr_d[1:0]);
        end else if (state_d == StAddM) begin
            select_d = {1'b0, q_d};
        end
        sel_valid_d = (state_d == StAddB) || (state_d == StAddM);
        busy_d      = (state_d != StIdle);
        last_iter_d = (cnt_d == LAST_CNT);
        done_d      = (state_d == StFinish);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= StIdle;
            a_sr_q      <= '0;
            cnt_q       <= '0;
            q_q         <= '0;
            mp_q        <= '0;
            select_q    <= SEL_ZERO;
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            last_iter_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sr_q      <= a_sr_d;
            cnt_q       <= cnt_d;
            q_q         <= q_d;
            mp_q        <= mp_d;
            select_q    <= select_d;
            sel_valid_q <= sel_valid_d;
            busy_q      <= busy_d;
            last_iter_q <= last_iter_d;
            done_q      <= done_d;
        end
    end

    assign bus.select    = select_q;
    assign bus.sel_valid = sel_valid_q;
    assign bus.busy      = busy_q;
    assign bus.last_iter = last_iter_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_montgomery_digit_sequencer.sv
// Bench for the digit sequencer: an 8-bit instance for directed and tabled
// cases, a 1024-bit instance for randomized runs against a digit-level model.
module tb_montgomery_digit_sequencer;

    logic clk = 1'b0;
    logic rstn_s, rstn_b;
    logic start_s, start_b;
    logic [1023:0] in_a;
    logic [1:0] m_low, c_low;
    logic add_done;
    bit use_big;

    logic [2:0] o_select;
    logic o_sel_valid, o_busy, o_last_iter, o_done;

    int n_tests = 0;
    int n_fail  = 0;
    int c_arr[512];
    logic [2:0] obs_sel[1024];

    always #5 clk = ~clk;

    montgomery_digit_sequencer_if #(.N_BITS(8))    if_s ();
    montgomery_digit_sequencer_if #(.N_BITS(1024)) if_b ();

    assign if_s.start    = start_s;
    assign if_s.in_A     = in_a[7:0];
    assign if_s.m_low    = m_low;
    assign if_s.c_low    = c_low;
    assign if_s.add_done = add_done;
    assign if_b.start    = start_b;
    assign if_b.in_A     = in_a;
    assign if_b.m_low    = m_low;
    assign if_b.c_low    = c_low;
    assign if_b.add_done = add_done;

    montgomery_digit_sequencer #(.N_BITS(8)) u_small (
        .clk    (clk),
        .resetn (rstn_s),
        .bus    (if_s)
    );

    montgomery_digit_sequencer #(.N_BITS(1024)) u_big (
        .clk    (clk),
        .resetn (rstn_b),
        .bus    (if_b)
    );

    always_comb begin
        o_select    = use_big ? if_b.select    : if_s.select;
        o_sel_valid = use_big ? if_b.sel_valid : if_s.sel_valid;
        o_busy      = use_big ? if_b.busy      : if_s.busy;
        o_last_iter = use_big ? if_b.last_iter : if_s.last_iter;
        o_done      = use_big ? if_b.done      : if_s.done;
    end

    task automatic check(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " select"},    int'(o_select),    0);
        check({tag, " sel_valid"}, int'(o_sel_valid), 0);
        check({tag, " busy"},      int'(o_busy),      0);
        check({tag, " last_iter"}, int'(o_last_iter), 0);
        check({tag, " done"},      int'(o_done),      0);
    endtask

    task automatic set_start(input bit big, input logic v);
        if (big) start_b = v;
        else     start_s = v;
    endtask

    // Runs one multiplication. dly = cycles from sel_valid to add_done;
    // poke = re-assert start in WAIT_B and add_done in ADD_M;
    // abort_dig >= 0 pulls reset during WAIT_M of that digit.
    task automatic run_op(input string name, input bit big, input logic [1023:0] a,
                          input logic [1:0] m, input int dly, input bit poke,
                          input int abort_dig);
        int ndig, nsel, pend, done_cnt, cyc, exp_done, mi, mp, d;
        bit start_next, aborted;
        logic [2:0] exp_seq[$];
        logic [2:0] last_sel;

        ndig = big ? 512 : 4;
        mi = int'(m);
        mp = 0;
        for (int x = 0; x < 4; x++) if ((mi * x + 1) % 4 == 0) mp = x;
        for (int i = 0; i < ndig; i++) begin
            d = int'(a[2*i +: 2]);
            exp_seq.push_back((d == 0) ? 3'd0 : 3'(3 + d));
            exp_seq.push_back(3'((c_arr[i] * mp) % 4));
        end
        exp_done = ndig * (2 + 2 * dly) + 1;

        use_big = big;
        @(posedge clk); #1;
        in_a = a;
        m_low = m;
        add_done = 1'b0;
        set_start(big, 1'b1);
        @(posedge clk); #1;
        set_start(big, 1'b0);

        cyc = 1; nsel = 0; pend = 0; done_cnt = 0;
        start_next = 0; aborted = 0; last_sel = 3'd0;
        while (cyc <= exp_done + 3) begin
            add_done = 1'b0;
            set_start(big, 1'b0);
            if (o_sel_valid) begin
                if (nsel < 2 * ndig) begin
                    check({name, " select"}, int'(o_select), int'(exp_seq[nsel]));
                    obs_sel[nsel] = o_select;
                end
                if (!big) check({name, " busy"}, int'(o_busy), 1);
                last_sel = o_select;
                nsel++;
                pend = dly;
                if (poke && (nsel % 2 == 1)) start_next = 1;
                if (poke && (nsel % 2 == 0)) add_done = 1'b1;
            end else begin
                if (start_next) begin
                    set_start(big, 1'b1);
                    start_next = 0;
                end
                if (pend > 0) begin
                    if (!big) begin
                        check({name, " held select"}, int'(o_select), int'(last_sel));
                        check({name, " busy in wait"}, int'(o_busy), 1);
                    end
                    pend--;
                    if (pend == 0) begin
                        if (abort_dig >= 0 && nsel == 2 * abort_dig + 2) begin
                            rstn_s = 1'b0;
                            aborted = 1;
                            @(posedge clk); #1;
                            cyc++;
                            rstn_s = 1'b1;
                            check_idle_outputs({name, " after abort"});
                            continue;
                        end
                        add_done = 1'b1;
                        c_low = 2'(c_arr[(nsel - 1) / 2]);
                    end
                end
            end
            if (!big && !aborted && nsel > 0 && done_cnt == 0)
                check({name, " last_iter"}, int'(o_last_iter), int'((nsel - 1) / 2 == ndig - 1));
            if (o_done) begin
                done_cnt++;
                check({name, " done cycle"}, cyc, exp_done);
            end
            @(posedge clk); #1;
            cyc++;
        end
        add_done = 1'b0;
        check({name, " select count"}, nsel, aborted ? 2 * abort_dig + 2 : 2 * ndig);
        check({name, " done pulses"}, done_cnt, aborted ? 0 : 1);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [1:0] m;
        int         c;
        logic [2:0] exp_b;
        logic [2:0] exp_m;
    } vec_t;

    vec_t vecs[6];
    logic [2:0] seq1[8];
    logic [2:0] seq4[8];

    initial begin
        vecs[0] = '{8'hE4, 2'b01, 2, 3'b000, 3'b010};
        vecs[1] = '{8'h1B, 2'b11, 3, 3'b110, 3'b011};
        vecs[2] = '{8'h01, 2'b11, 1, 3'b100, 3'b001};
        vecs[3] = '{8'h42, 2'b01, 1, 3'b101, 3'b011};
        vecs[4] = '{8'hFF, 2'b01, 3, 3'b110, 3'b001};
        vecs[5] = '{8'h00, 2'b11, 2, 3'b000, 3'b010};
        seq1 = '{3'b000, 3'b000, 3'b100, 3'b000, 3'b101, 3'b000, 3'b110, 3'b000};
        seq4 = '{3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};

        rstn_s = 1'b0; rstn_b = 1'b0;
        start_s = 1'b0; start_b = 1'b0;
        in_a = '0; m_low = 2'b01; c_low = 2'b00; add_done = 1'b0;
        use_big = 0;
        foreach (c_arr[i]) c_arr[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset small");
        use_big = 1;
        check_idle_outputs("reset big");
        rstn_s = 1'b1; rstn_b = 1'b1;

        // Basic walk with zero accumulator bits.
        run_op("t1", 0, 1024'hE4, 2'b01, 1, 0, -1);
        for (int i = 0; i < 8; i++) check("t1 seq", int'(obs_sel[i]), int'(seq1[i]));

        // Quotient digit table.
        for (int v = 0; v < 6; v++) begin
            foreach (c_arr[i]) c_arr[i] = 0;
            c_arr[0] = vecs[v].c;
            run_op("t2", 0, 1024'(vecs[v].a), vecs[v].m, 1, 0, -1);
            check("t2 first B", int'(obs_sel[0]), int'(vecs[v].exp_b));
            check("t2 first M", int'(obs_sel[1]), int'(vecs[v].exp_m));
        end
        foreach (c_arr[i]) c_arr[i] = 0;

        // Spurious start and add_done must be ignored.
        run_op("t3", 0, 1024'hE4, 2'b01, 1, 1, -1);
        for (int i = 0; i < 8; i++) check("t3 seq", int'(obs_sel[i]), int'(seq1[i]));

        // Abort mid-operation, then a clean run.
        run_op("t4 abort", 0, 1024'hE4, 2'b01, 1, 0, 2);
        run_op("t4", 0, 1024'h01, 2'b11, 1, 0, -1);
        for (int i = 0; i < 8; i++) check("t4 seq", int'(obs_sel[i]), int'(seq4[i]));

        // Slow adder.
        run_op("t5", 0, 1024'h9C, 2'b11, 5, 0, -1);

        // Full width randomized runs.
        for (int r = 0; r < 2; r++) begin
            logic [1023:0] ra;
            for (int w = 0; w < 32; w++) ra[32*w +: 32] = $urandom;
            foreach (c_arr[i]) c_arr[i] = int'($urandom_range(0, 3));
            run_op("t6", 1, ra, ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b01,
                   int'($urandom_range(1, 2)), 0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
